stream_dispatcher: RTL and testbench

Routes a single valid/ready input stream to one of `2**ADDRESS_WIDTH` output channels, with a one-entry holding register per channel. This block is the sequenced, flow-controlled front end for the plumbing demultiplexor path: it selects the destination either from the per-beat address or from an internal round-robin pointer. It also keeps a saturating count of accepted beats.

---
 rtl/stream_dispatcher.sv | 93 +++++++++
 tb/tb_stream_dispatcher.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/stream_dispatcher.sv
// Valid/ready demultiplexor: routes one input stream to 2**ADDRESS_WIDTH channels,
// each backed by a one-entry holding slot, with address or round-robin selection.
module stream_dispatcher #(
    parameter int ADDRESS_WIDTH = 2,
    parameter int DATA_WIDTH    = 8,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   rr_mode,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [ADDRESS_WIDTH-1:0]               in_addr,
    input  logic [DATA_WIDTH-1:0]                  in_data,
    output logic [(2**ADDRESS_WIDTH)-1:0]          out_valid,
    input  logic [(2**ADDRESS_WIDTH)-1:0]          out_ready,
    output logic [(2**ADDRESS_WIDTH)*DATA_WIDTH-1:0] out_data,
    output logic [ADDRESS_WIDTH-1:0]               rr_ptr,
    output logic [COUNT_WIDTH-1:0]                 xfer_count
);

    localparam int N = 2**ADDRESS_WIDTH;

    logic [ADDRESS_WIDTH-1:0]  sel_s;
    logic                      ready_s;
    logic                      accept_s;
    logic [N-1:0]              valid_r;
    logic [N*DATA_WIDTH-1:0]   data_r;
    logic [ADDRESS_WIDTH-1:0]  ptr_r;
    logic [COUNT_WIDTH-1:0]    count_r;

    // Destination select and input acceptance; a slot draining this cycle can take a new beat.
    always_comb begin
        sel_s    = in_addr;
        ready_s  = 1'b0;
        accept_s = 1'b0;
        if (rr_mode) begin
            sel_s = ptr_r;
        end else begin
            sel_s = in_addr;
        end
        ready_s  = (!valid_r[sel_s]) || out_ready[sel_s];
        accept_s = in_valid && ready_s;
    end

    // Per-channel holding slots: reload wins over drain so throughput stays one beat per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= {N{1'b0}};
            data_r  <= {(N*DATA_WIDTH){1'b0}};
        end else begin
            for (int i = 0; i < N; i++) begin
                if (accept_s && (sel_s == ADDRESS_WIDTH'(i))) begin
                    valid_r[i]                           <= 1'b1;
                    data_r[i*DATA_WIDTH +: DATA_WIDTH]   <= in_data;
                end else if (valid_r[i] && out_ready[i]) begin
                    valid_r[i] <= 1'b0;
                end else begin
                    valid_r[i] <= valid_r[i];
                end
            end
        end
    end

    // Round-robin pointer moves only on a round-robin accept; wrap is natural modulo N.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= {ADDRESS_WIDTH{1'b0}};
        end else if (accept_s && rr_mode) begin
            ptr_r <= ptr_r + ADDRESS_WIDTH'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Saturating accepted-beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {COUNT_WIDTH{1'b0}};
        end else if (accept_s && (count_r != {COUNT_WIDTH{1'b1}})) begin
            count_r <= count_r + COUNT_WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign in_ready   = ready_s;
    assign out_valid  = valid_r;
    assign out_data   = data_r;
    assign rr_ptr     = ptr_r;
    assign xfer_count = count_r;

endmodule

// File: tb/tb_stream_dispatcher.sv
// Directed plus randomized bench for stream_dispatcher against a per-channel slot model.
module tb_stream_dispatcher;

    localparam int AW = 2;
    localparam int DW = 8;
    localparam int CW = 4;
    localparam int N  = 4;
    localparam int CMAX = 15;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            rr_mode = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [AW-1:0]   in_addr = 2'd0;
    logic [DW-1:0]   in_data = 8'd0;
    logic [N-1:0]    out_valid;
    logic [N-1:0]    out_ready = 4'b0000;
    logic [N*DW-1:0] out_data;
    logic [AW-1:0]   rr_ptr;
    logic [CW-1:0]   xfer_count;

    int tests = 0;
    int fails = 0;

    // model state
    bit       m_v [N];
    int       m_d [N];
    int       m_ptr;
    int       m_cnt;

    stream_dispatcher #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .rr_mode(rr_mode), .in_valid(in_valid),
        .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .rr_ptr(rr_ptr), .xfer_count(xfer_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_v[i] = 1'b0;
            m_d[i] = 0;
        end
        m_ptr = 0;
        m_cnt = 0;
    endtask

    task automatic check_outputs(input string tag);
        logic [N-1:0] ev;
        for (int i = 0; i < N; i++) ev[i] = m_v[i];
        chk({tag, "_valid"}, 64'(out_valid), 64'(ev));
        chk({tag, "_ptr"}, 64'(rr_ptr), 64'(m_ptr));
        chk({tag, "_count"}, 64'(xfer_count), 64'(m_cnt));
        for (int i = 0; i < N; i++) begin
            if (m_v[i]) chk({tag, "_data"}, 64'(out_data[i*DW +: DW]), 64'(m_d[i]));
        end
    endtask

    // One clock: check in_ready against the model, advance model over the edge, check outputs.
    task automatic tick(input string tag);
        int  sel;
        bit  rdy;
        bit  acc;
        #1;
        sel = rr_mode ? m_ptr : int'(in_addr);
        rdy = !m_v[sel] || out_ready[sel];
        acc = in_valid && rdy;
        chk({tag, "_in_ready"}, 64'(in_ready), 64'(rdy));
        @(posedge clk);
        for (int i = 0; i < N; i++) if (m_v[i] && out_ready[i]) m_v[i] = 1'b0;
        if (acc) begin
            m_v[sel] = 1'b1;
            m_d[sel] = int'(in_data);
            if (rr_mode) m_ptr = (m_ptr + 1) % N;
            if (m_cnt < CMAX) m_cnt = m_cnt + 1;
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_data", 64'(out_data), 64'd0);
        check_outputs("reset");
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset();

        // Reset values and asynchronous assert mid-cycle
        rr_mode = 1'b0; in_valid = 1'b1; in_addr = 2'd2; in_data = 8'hA5; out_ready = 4'b0000;
        tick("first_beat");
        chk("first_valid", 64'(out_valid), 64'(4'b0100));
        chk("first_data", 64'(out_data[2*DW +: DW]), 64'hA5);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", 64'(out_valid), 64'd0);
        chk("async_count", 64'(xfer_count), 64'd0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick("after_reset");

        // Backpressure on channel 1
        out_ready = 4'b1101; in_valid = 1'b1; in_addr = 2'd1; in_data = 8'h11;
        tick("bp_first");
        in_data = 8'h22;
        #1 chk("bp_stall", 64'(in_ready), 64'd0);
        tick("bp_hold");
        chk("bp_hold_data", 64'(out_data[1*DW +: DW]), 64'h11);
        chk("bp_hold_count", 64'(xfer_count), 64'd1);
        out_ready = 4'b1111;
        tick("bp_release");
        chk("bp_new_data", 64'(out_data[1*DW +: DW]), 64'h22);
        chk("bp_count2", 64'(xfer_count), 64'd2);
        in_valid = 1'b0;
        tick("bp_drain");

        // Back-to-back drain and reload on channel 3
        in_valid = 1'b1; in_addr = 2'd3;
        for (int k = 1; k <= 8; k++) begin
            in_data = 8'(k);
            tick("stream");
            chk("stream_v3", 64'(out_valid[3]), 64'd1);
        end
        in_valid = 1'b0;
        tick("stream_end");

        // Round-robin wrap
        do_reset();
        rr_mode = 1'b1; out_ready = 4'b1111; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_data = 8'(8'h40 + k);
            tick("rr");
            chk("rr_channel", 64'(out_valid), 64'(4'b0001 << (k % 4)));
        end
        chk("rr_ptr_end", 64'(rr_ptr), 64'd1);
        // Fill channel 1 by address, then stall the round-robin input on it
        rr_mode = 1'b0; in_addr = 2'd1; in_data = 8'h77; out_ready = 4'b1101;
        tick("rr_fill");
        rr_mode = 1'b1; in_data = 8'h78;
        tick("rr_stall");
        tick("rr_stall2");
        chk("rr_stall_ptr", 64'(rr_ptr), 64'd1);
        out_ready = 4'b1111;
        tick("rr_unstall");
        chk("rr_unstall_ptr", 64'(rr_ptr), 64'd2);

        // Mode switch preserves the pointer
        rr_mode = 1'b0; in_addr = 2'd0; in_data = 8'h90;
        tick("mode_addr");
        chk("mode_ptr_hold", 64'(rr_ptr), 64'd2);
        rr_mode = 1'b1; in_data = 8'h91;
        tick("mode_rr");
        chk("mode_rr_ch2", 64'(out_valid), 64'(4'b0100));

        // Counter saturation
        do_reset();
        rr_mode = 1'b0; out_ready = 4'b1111; in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_addr = 2'(k);
            in_data = 8'(k);
            tick("sat");
        end
        chk("sat_count", 64'(xfer_count), 64'd15);

        // Randomized traffic
        do_reset();
        for (int k = 0; k < 400; k++) begin
            rr_mode   = 1'($urandom_range(0, 1));
            in_valid  = ($urandom_range(0, 3) != 0);
            in_addr   = 2'($urandom);
            in_data   = 8'($urandom);
            out_ready = 4'($urandom);
            tick("rand");
            if (k == 200) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
